regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-entry register file with a write-to-read bypass and a per-register pending-write scoreboard, for the pipelined processor's decode stage. Two combinational read ports and one synchronous write-back port. The scoreboard tracks registers with an in-flight producer, and its busy flags drive the hazard/stall logic. Generalises the fixed 8x16 register file in width and depth and adds reset, bypass and hazard tracking.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W entries
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- rd1_data  out  DATA_W  read port 1 data (combinational)
- rd2_data  out  DATA_W  read port 2 data (combinational)
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back data
- alloc_en  in  1  issue of an instruction with destination alloc_addr; marks it pending
- alloc_addr  in  ADDR_W  destination being allocated
- busy1  out  1  rs1_addr has an outstanding producer (combinational)
- busy2  out  1  rs2_addr has an outstanding producer (combinational)
- busy_vec  out  NREGS  registered pending bits, bit i = register i
- alloc_err  out  1  registered; 1-cycle pulse on allocating an already-pending register (WAW)

## Operation
- Storage: NREGS x DATA_W flops, plus pend[NREGS].
- Write: on a clk edge with wr_en=1, regs[wr_addr] <= wr_data and pend[wr_addr] <= 0.
- Allocation: on a clk edge with alloc_en=1, pend[alloc_addr] <= 1.
- Allocation to a register whose pend bit is already 1 still records the allocation (bit stays 1). alloc_err is 1 for the following cycle only.
- Simultaneous wr_en and alloc_en to the same address: the data is written, and pend ends at 1 because allocation wins. alloc_err is not raised, since the old producer retires this cycle.
- Read, per port: if wr_en=1 and wr_addr equals the port address, the output is wr_data (write-first bypass). Otherwise the output is regs[addr].
- busyN = pend[rsN_addr] & ~(wr_en & wr_addr==rsN_addr). A same-cycle write-back satisfies the hazard.
- Both read ports may address the same register; bypass and busy apply independently to each.
- All arithmetic is address equality only; no data modification.

## Timing
- Reset (rst_n=0, asynchronous, any time, including mid-write): all regs=0, pend=0, alloc_err=0.
- While rst_n=0: rd1_data, rd2_data, busy1 and busy2 are forced to 0, and writes/allocations are ignored. State is reset-valued on the first edge after release.
- Read latency: 0 cycles (combinational) from address or bypass inputs.
- Write visibility: same cycle via bypass; from the array on the cycle after the edge.
- Allocation visibility: busy/busy_vec asserted from the cycle after the alloc edge.
- Write-back clear: busy drops in the write-back cycle (combinational), and busy_vec drops after the edge.
- alloc_err: asserted exactly one cycle after the offending edge; back-to-back offending allocations give a continuous high.

## Configuration
- REGFILE_R0_ZERO_EN defined: register 0 is hardwired to zero.
  - Writes to address 0 are discarded and never bypassed.
  - Allocations to address 0 are ignored, with no pend bit and no alloc_err.
  - Reads of address 0 return 0 and busy is 0.
  - busy_vec[0] is constant 0.
- REGFILE_R0_ZERO_EN undefined: register 0 behaves like any other register.

## Test plan
Defaults DATA_W=16, ADDR_W=3.
- Reset mid-write: assert rst_n=0 with wr_en=1, wr_addr=5, wr_data=16'h1234 -> all reads return 16'h0000, busy_vec=8'h00, alloc_err=0 after release.
- Write/read with bypass: wr_en=1, wr_addr=3, wr_data=16'hCCCC, rs1_addr=3 -> rd1_data=16'hCCCC in the same cycle. Next cycle with wr_en=0 -> rd1_data still 16'hCCCC.
- Scoreboard: alloc_en=1, alloc_addr=4 -> busy_vec=8'h10 next cycle and busy2=1 with rs2_addr=4. Then wr_en=1, wr_addr=4, wr_data=16'hDDDD -> busy2=0 and rd2_data=16'hDDDD in that cycle, busy_vec=8'h00 after.
- WAW and simultaneous events: allocate reg 2 twice on consecutive cycles -> one-cycle alloc_err=1. Allocate and write reg 6 in the same cycle -> busy_vec[6]=1 after, alloc_err=0.
- Dual-port same address: rs1_addr=rs2_addr=7 after writing 16'hEEEE -> rd1_data=rd2_data=16'hEEEE.
- With REGFILE_R0_ZERO_EN: wr_en=1, wr_addr=0, wr_data=16'hFFFF, plus alloc of reg 0 -> rd data from reg 0 is 16'h0000, busy_vec[0]=0, alloc_err=0. Without the macro, the same stimulus gives 16'hFFFF.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-first bypass and a pending-write scoreboard.
// Optional REGFILE_R0_ZERO_EN hardwires register 0 to zero. Revision 1.0
`default_nettype none

module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  localparam int NREGS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [NREGS-1:0]  busy_vec,
  output logic              alloc_err
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              alloc_err_q, alloc_err_d;
  logic              wr_eff, alloc_eff;

  // With R0 hardwired, traffic targeting register 0 simply never happens.
  assign wr_eff    = wr_en    & ~(R0_ZERO & (wr_addr    == ADDR_W'(0)));
  assign alloc_eff = alloc_en & ~(R0_ZERO & (alloc_addr == ADDR_W'(0)));

  always_comb begin
    regs_d      = regs_q;
    pend_d      = pend_q;
    alloc_err_d = 1'b0;
    if (wr_eff) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (alloc_eff) begin
      pend_d[alloc_addr] = 1'b1;
      // A retiring producer on the same register makes the re-allocation legal.
      alloc_err_d = pend_q[alloc_addr] & ~(wr_eff & (wr_addr == alloc_addr));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q      <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pend_q      <= pend_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (wr_eff && (wr_addr == addr)) return wr_data;
    return regs_q[addr];
  endfunction

  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    busy1    = 1'b0;
    busy2    = 1'b0;
    if (rst_n) begin
      rd1_data = read_port(rs1_addr);
      rd2_data = read_port(rs2_addr);
      busy1    = pend_q[rs1_addr] & ~(wr_eff & (wr_addr == rs1_addr));
      busy2    = pend_q[rs2_addr] & ~(wr_eff & (wr_addr == rs2_addr));
    end
  end

  assign busy_vec  = pend_q;
  assign alloc_err = alloc_err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with a behavioural array model.
`default_nettype none

module tb_regfile_sb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1_addr, rs2_addr, wr_addr, alloc_addr;
  logic [DW-1:0] rd1_data, rd2_data, wr_data;
  logic          wr_en, alloc_en, busy1, busy2, alloc_err;
  logic [NR-1:0] busy_vec;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          b1;
    logic          b2;
    logic [NR-1:0] bv;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 0;
  endfunction

  function automatic bit is_r0(input int a);
    return R0Z && (a == 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input int a, input bit we, input int wa,
                                            input logic [DW-1:0] wd);
    if (is_r0(a)) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic cycle(input bit rst, input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit ae, input int aa, input int r1, input int r2);
    exp_t e;
    bit   wv, av;
    rst_n = rst; wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    alloc_en = ae; alloc_addr = AW'(aa); rs1_addr = AW'(r1); rs2_addr = AW'(r2);
    if (!rst) model_clear();
    wv = we && !is_r0(wa);
    av = ae && !is_r0(aa);
    if (rst) begin
      e.rd1 = m_read(r1, wv, wa, wd);
      e.rd2 = m_read(r2, wv, wa, wd);
      e.b1  = m_pend[r1] && !(wv && wa == r1);
      e.b2  = m_pend[r2] && !(wv && wa == r2);
    end else begin
      e.rd1 = '0; e.rd2 = '0; e.b1 = 1'b0; e.b2 = 1'b0;
    end
    for (int i = 0; i < NR; i++) e.bv[i] = m_pend[i];
    e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_err = av && m_pend[aa] && !(wv && wa == aa);
      if (wv) begin
        m_regs[wa] = wd;
        m_pend[wa] = 0;
      end
      if (av) m_pend[aa] = 1;
    end
    @(negedge clk);
  endtask

  // Monitor: compares every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd1_data",  32'(rd1_data),  32'(e.rd1));
        chk("rd2_data",  32'(rd2_data),  32'(e.rd2));
        chk("busy1",     32'(busy1),     32'(e.b1));
        chk("busy2",     32'(busy2),     32'(e.b2));
        chk("busy_vec",  32'(busy_vec),  32'(e.bv));
        chk("alloc_err", 32'(alloc_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rs1_addr = '0; rs2_addr = '0;
    model_clear();
    @(negedge clk);
    cycle(0, 0, 0, 16'h0, 0, 0, 0, 0);
    cycle(1, 1, 1, 16'hABCD, 1, 5, 1, 5);
    cycle(1, 0, 0, 16'h0, 0, 0, 1, 5);
    // reset asserted while a write is presented
    cycle(0, 1, 5, 16'h1234, 0, 0, 5, 1);
    cycle(1, 0, 0, 16'h0, 0, 0, 5, 1);
    cycle(1, 0, 0, 16'h0, 0, 0, 5, 5);
    // bypass then array read
    cycle(1, 1, 3, 16'hCCCC, 0, 0, 3, 0);
    cycle(1, 0, 0, 16'h0, 0, 0, 3, 0);
    // scoreboard set and write-back clear
    cycle(1, 0, 0, 16'h0, 1, 4, 0, 4);
    cycle(1, 0, 0, 16'h0, 0, 0, 0, 4);
    cycle(1, 1, 4, 16'hDDDD, 0, 0, 0, 4);
    cycle(1, 0, 0, 16'h0, 0, 0, 4, 4);
    // WAW on reg 2, then simultaneous alloc+write on reg 6
    cycle(1, 0, 0, 16'h0, 1, 2, 2, 2);
    cycle(1, 0, 0, 16'h0, 1, 2, 2, 2);
    cycle(1, 0, 0, 16'h0, 1, 2, 2, 2);
    cycle(1, 0, 0, 16'h0, 0, 0, 2, 2);
    cycle(1, 0, 0, 16'h0, 1, 6, 6, 6);
    cycle(1, 1, 6, 16'h6666, 1, 6, 6, 6);
    cycle(1, 0, 0, 16'h0, 0, 0, 6, 6);
    // dual-port same address
    cycle(1, 1, 7, 16'hEEEE, 0, 0, 7, 7);
    cycle(1, 0, 0, 16'h0, 0, 0, 7, 7);
    // register 0 write + allocation
    cycle(1, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    cycle(1, 0, 0, 16'h0, 0, 0, 0, 0);
    cycle(1, 0, 0, 16'h0, 1, 0, 0, 0);
    cycle(1, 0, 0, 16'h0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, NR-1)), 16'($urandom),
            1'($urandom_range(0, 2) == 0), int'($urandom_range(0, NR-1)),
            int'($urandom_range(0, NR-1)), int'($urandom_range(0, NR-1)));
    end
    cycle(1, 0, 0, 16'h0, 0, 0, 1, 2);
    @(negedge clk);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
